// File: rtl/alu_serial_pkg.sv
// Shared opcodes, FSM state and bit-cell mode encoding for the bit-serial ALU.
package alu_serial_pkg;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB_XY = 4'd1;
    localparam logic [3:0] OP_SUB_YX = 4'd2;
    localparam logic [3:0] OP_ZERO   = 4'd3;
    localparam logic [3:0] OP_ONE    = 4'd4;
    localparam logic [3:0] OP_ONES   = 4'd5;
    localparam logic [3:0] OP_NEG_X  = 4'd6;
    localparam logic [3:0] OP_NEG_Y  = 4'd7;
    localparam logic [3:0] OP_NOT_X  = 4'd8;
    localparam logic [3:0] OP_NOT_Y  = 4'd9;
    localparam logic [3:0] OP_INC_X  = 4'd10;
    localparam logic [3:0] OP_INC_Y  = 4'd11;
    localparam logic [3:0] OP_DEC_X  = 4'd12;
    localparam logic [3:0] OP_DEC_Y  = 4'd13;
    localparam logic [3:0] OP_AND    = 4'd14;
    localparam logic [3:0] OP_OR     = 4'd15;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef enum logic [1:0] {MODE_ADD, MODE_AND, MODE_OR} cell_mode_t;

    function automatic logic op_is_logic(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic cell_mode_t op_mode(input logic [3:0] op);
        if (!op_is_logic(op)) return MODE_ADD;
        return (op == OP_AND) ? MODE_AND : MODE_OR;
    endfunction

endpackage

// File: rtl/alu_bit_cell.sv
// One-bit full adder with AND/OR bypass; the single compute cell of the serial ALU.
module alu_bit_cell
    import alu_serial_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  cell_mode_t mode,
    output logic       s,
    output logic       cout
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        s    = 1'b0;
        cout = 1'b0;
        case (mode)
            MODE_ADD: begin
                s    = a ^ b ^ cin;
                cout = (a & b) | (a & cin) | (b & cin);
            end
            MODE_AND: s = a & b;
            MODE_OR:  s = a | b;
            default:  s = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_unit.sv
// Bit-serial ALU: one command in, WIDTH cycles through one bit cell, one result out.
// Define ALU_SERIAL_FLAGS_EN to add the out_zero / out_neg result flags.
module alu_serial_unit
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry
`ifdef ALU_SERIAL_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_neg
`endif
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cell_mode_t       mode_q, mode_d;

    logic [WIDTH-1:0] a_sel, b_sel;
    logic             c0_sel;
    logic             cell_s, cell_cout;
    logic             accept;

    assign accept = in_valid && in_ready;

    alu_bit_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .mode (mode_q),
        .s    (cell_s),
        .cout (cell_cout)
    );

    // Every opcode reduces to A + B + c0 (or a bitwise op on x, y).
    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        c0_sel = 1'b0;
        case (in_op)
            OP_ADD:    begin a_sel = in_x; b_sel = in_y; end
            OP_SUB_XY: begin a_sel = in_x; b_sel = ~in_y; c0_sel = 1'b1; end
            OP_SUB_YX: begin a_sel = in_y; b_sel = ~in_x; c0_sel = 1'b1; end
            OP_ZERO:   ;
            OP_ONE:    c0_sel = 1'b1;
            OP_ONES:   b_sel = '1;
            OP_NEG_X:  begin b_sel = ~in_x; c0_sel = 1'b1; end
            OP_NEG_Y:  begin b_sel = ~in_y; c0_sel = 1'b1; end
            OP_NOT_X:  b_sel = ~in_x;
            OP_NOT_Y:  b_sel = ~in_y;
            OP_INC_X:  begin a_sel = in_x; c0_sel = 1'b1; end
            OP_INC_Y:  begin a_sel = in_y; c0_sel = 1'b1; end
            OP_DEC_X:  begin a_sel = in_x; b_sel = '1; end
            OP_DEC_Y:  begin a_sel = in_y; b_sel = '1; end
            OP_AND, OP_OR: begin a_sel = in_x; b_sel = in_y; end
            default:   ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (cnt_q == LAST_BIT) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        if (state_q == IDLE && accept) begin
            a_d     = a_sel;
            b_d     = b_sel;
            carry_d = c0_sel && !op_is_logic(in_op);
            cnt_d   = '0;
            mode_d  = op_mode(in_op);
        end else if (state_q == RUN) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = {cell_s, res_q[WIDTH-1:1]};
            carry_d = cell_cout;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= MODE_ADD;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        out_result = res_q;
        out_carry  = carry_q;
    end

`ifdef ALU_SERIAL_FLAGS_EN
    // Sticky "some result bit was 1"; zero flag is its complement once the result is valid.
    logic nz_q, nz_d;

    always_comb begin
        nz_d = nz_q;
        if (state_q == IDLE && accept) nz_d = 1'b0;
        else if (state_q == RUN)       nz_d = nz_q | cell_s;
    end

    always_ff @(posedge clk) begin
        if (rst) nz_q <= 1'b0;
        else     nz_q <= nz_d;
    end

    assign out_zero = out_valid & ~nz_q;
    assign out_neg  = out_valid & res_q[WIDTH-1];
`endif

endmodule

// File: tb/tb_alu_serial_unit.sv
// Self-checking bench for alu_serial_unit: directed cases plus random commands against a arithmetic model.
module tb_alu_serial_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_op;
    logic [W-1:0] in_x, in_y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_carry;
`ifdef ALU_SERIAL_FLAGS_EN
    logic         out_zero, out_neg;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_serial_unit #(.WIDTH(W), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_x       (in_x),
        .in_y       (in_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry)
`ifdef ALU_SERIAL_FLAGS_EN
        ,
        .out_zero   (out_zero),
        .out_neg    (out_neg)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {carry, result} straight from the arithmetic meaning of each opcode.
    function automatic logic [16:0] model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        case (op)
            4'd0:  return {1'b0, x} + {1'b0, y};
            4'd1:  return {x >= y, x - y};
            4'd2:  return {y >= x, y - x};
            4'd3:  return 17'h0_0000;
            4'd4:  return 17'h0_0001;
            4'd5:  return 17'h0_FFFF;
            4'd6:  return {x == 16'h0, 16'h0 - x};
            4'd7:  return {y == 16'h0, 16'h0 - y};
            4'd8:  return {1'b0, ~x};
            4'd9:  return {1'b0, ~y};
            4'd10: return {x == 16'hFFFF, x + 16'h1};
            4'd11: return {y == 16'hFFFF, y + 16'h1};
            4'd12: return {x != 16'h0, x - 16'h1};
            4'd13: return {y != 16'h0, y - 16'h1};
            4'd14: return {1'b0, x & y};
            default: return {1'b0, x | y};
        endcase
    endfunction

    // Present a command and return just after the edge that accepts it.
    task automatic send(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_x = x; in_y = y;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("accept_timeout", 32'(guard < 100), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Called right after the accept edge; stops at the negedge where out_valid is seen.
    task automatic wait_result(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        logic [16:0] exp = model(op, x, y);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        check("latency", lat, W + 1);
        check($sformatf("result_op%0d", op), out_result, exp[15:0]);
        check($sformatf("carry_op%0d", op), out_carry, exp[16]);
        check("in_ready_done", in_ready, 1'b0);
`ifdef ALU_SERIAL_FLAGS_EN
        check("zero_flag", out_zero, exp[15:0] == 16'h0);
        check("neg_flag", out_neg, exp[15]);
`endif
    endtask

    task automatic release_result(input int hold);
        logic [15:0] held = out_result;
        repeat (hold) begin
            @(negedge clk);
            check("hold_result", out_result, held);
            check("hold_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("valid_dropped", out_valid, 1'b0);
        check("ready_back", in_ready, 1'b1);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y, input int hold);
        send(op, x, y);
        wait_result(op, x, y);
        release_result(hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises;
        logic [15:0] held;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 4'd0; in_x = '0; in_y = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, 16'h0000);
        check("rst_out_carry", out_carry, 1'b0);
        rst = 1'b0;

        // Reset in the middle of RUN aborts silently.
        send(4'd0, 16'h1234, 16'h1111);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_out_result", out_result, 16'h0000);
        rises = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) rises++;
        end
        check("abort_no_valid", rises, 0);

        run_op(4'd0,  16'hFFFF, 16'h0001, 0);
        run_op(4'd1,  16'h0003, 16'h0005, 0);
        run_op(4'd2,  16'h0003, 16'h0005, 1);
        run_op(4'd5,  16'h1234, 16'h5678, 0);
        run_op(4'd6,  16'h0001, 16'h0000, 0);
        run_op(4'd8,  16'h00F0, 16'h0000, 0);
        run_op(4'd12, 16'h0000, 16'h0000, 0);
        run_op(4'd14, 16'hF0F0, 16'h3C3C, 0);
        run_op(4'd15, 16'hF0F0, 16'h3C3C, 0);
        run_op(4'd1,  16'h1234, 16'h1234, 0);
        run_op(4'd7,  16'h0000, 16'h0001, 0);
        run_op(4'd4,  16'hAAAA, 16'h5555, 0);
        run_op(4'd3,  16'hAAAA, 16'h5555, 0);

        // Backpressure with a second command waiting at the input.
        send(4'd1, 16'h0003, 16'h0005);
        wait_result(4'd1, 16'h0003, 16'h0005);
        held = out_result;
        in_valid = 1'b1; in_op = 4'd2; in_x = 16'h0003; in_y = 16'h0005;
        repeat (10) begin
            @(negedge clk);
            check("bp_result", out_result, held);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp_idle_ready", in_ready, 1'b1);
        check("bp_idle_valid", out_valid, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result(4'd2, 16'h0003, 16'h0005);
        release_result(0);

        for (int i = 0; i < 40; i++) begin
            run_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
